// File: rtl/nubus_pkg.sv
// nubus_pkg: shared sequencer state codes, START transfer-mode encodings and ACK status codes.
// TM values are active-high; the bus carries their complement.
package nubus_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_FAIR  = 3'd1;
  localparam state_t ST_ARB   = 3'd2;
  localparam state_t ST_OWN   = 3'd3;
  localparam state_t ST_START = 3'd4;
  localparam state_t ST_DATA  = 3'd5;

  // Transfer mode presented with START
  localparam logic [1:0] TM_WRITE_WORD = 2'b00;
  localparam logic [1:0] TM_READ_WORD  = 2'b01;
  localparam logic [1:0] TM_WRITE_BYTE = 2'b10;
  localparam logic [1:0] TM_READ_BYTE  = 2'b11;

  // Completion status returned with ACK
  localparam logic [1:0] TM_OK    = 2'b00;
  localparam logic [1:0] TM_ERR   = 2'b01;
  localparam logic [1:0] TM_TMO   = 2'b10;
  localparam logic [1:0] TM_RETRY = 2'b11;

endpackage

// File: rtl/nubus_master_seq_if.sv
// nubus_master_seq_if: bridge request/completion handshake, transceiver-stage controls and sensed bus lines.
// master = sequencer view, slave = bridge/transceiver view.
interface nubus_master_seq_if;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_tm;
  logic       done_valid;
  logic [1:0] done_tm;
  logic       done_timeout;
  logic       grant;
  logic       rqst_bus_n;
  logic       start_bus_n;
  logic       ack_bus_n;
  logic [1:0] tm_bus_n;
  logic       rqst_n;
  logic       rqst_oe_n;
  logic       arbcy_n;
  logic       nubus_master_dir;
  logic       start_n;
  logic [1:0] tm_n;
  logic       ad_oe_n;

  modport master (
    input  req_valid, req_tm, grant, rqst_bus_n, start_bus_n, ack_bus_n, tm_bus_n,
    output req_ready, done_valid, done_tm, done_timeout,
    output rqst_n, rqst_oe_n, arbcy_n, nubus_master_dir, start_n, tm_n, ad_oe_n
  );

  modport slave (
    output req_valid, req_tm, grant, rqst_bus_n, start_bus_n, ack_bus_n, tm_bus_n,
    input  req_ready, done_valid, done_tm, done_timeout,
    input  rqst_n, rqst_oe_n, arbcy_n, nubus_master_dir, start_n, tm_n, ad_oe_n
  );
endinterface

// File: rtl/nubus_busy_tracker.sv
// nubus_busy_tracker: bus-busy flag, set by a sensed START and cleared by a sensed ACK.
// Registered, one clock behind the bus lines; START+ACK together (attention cycle) leaves it clear.
module nubus_busy_tracker (
  input  logic nubus_clk,
  input  logic nubus_rst,
  input  logic start_bus_n,
  input  logic ack_bus_n,
  output logic busy
);

  always_ff @(posedge nubus_clk) begin
    if (nubus_rst) begin
      busy <= 1'b0;
    end else if (!start_bus_n && !ack_bus_n) begin
      busy <= 1'b0;
    end else if (!start_bus_n) begin
      busy <= 1'b1;
    end else if (!ack_bus_n) begin
      busy <= 1'b0;
    end
  end

endmodule

// File: rtl/nubus_master_seq.sv
// nubus_master_seq: NuBus master cycle sequencer - fairness, arbitration, START, then ACK or timeout.
// All outputs registered; ACK timeout exists only when NUBUS_MASTER_TIMEOUT_EN is defined.
module nubus_master_seq
  import nubus_pkg::*;
#(
  parameter int ARB_SETTLE = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic               nubus_clk,
  input  logic               nubus_rst,
  nubus_master_seq_if.master bus
);

  localparam int ACW = $clog2(ARB_SETTLE + 1);

  state_t         state_q;
  state_t         state_nxt;
  logic [ACW-1:0] arb_cnt;
  logic [1:0]     tm_q;
  logic           busy;
  logic           accept;
  logic           arb_done;
  logic           ack_seen;
  logic           tmo_hit;
  logic           done_evt;
  logic           hold_rqst;
  logic           drive_ad;

  nubus_busy_tracker u_busy (
    .nubus_clk   (nubus_clk),
    .nubus_rst   (nubus_rst),
    .start_bus_n (bus.start_bus_n),
    .ack_bus_n   (bus.ack_bus_n),
    .busy        (busy)
  );

  assign accept   = (state_q == ST_IDLE) && bus.req_valid;
  assign arb_done = (arb_cnt == ACW'(ARB_SETTLE - 1));
  assign ack_seen = (state_q == ST_DATA) && !bus.ack_bus_n;

`ifdef NUBUS_MASTER_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT + 1);
  logic [TCW-1:0] tmo_cnt;

  // Zero in the first DATA clock; the edge that would take it to TIMEOUT fires.
  always_ff @(posedge nubus_clk) begin
    if (nubus_rst || state_q != ST_DATA) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign tmo_hit = (state_q == ST_DATA) && bus.ack_bus_n && (tmo_cnt == TCW'(TIMEOUT - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  assign done_evt = ack_seen || tmo_hit;

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) state_nxt = bus.rqst_bus_n ? ST_ARB : ST_FAIR;
      end
      ST_FAIR: begin
        if (bus.rqst_bus_n) state_nxt = ST_ARB;
      end
      ST_ARB: begin
        if (arb_done && bus.grant) state_nxt = ST_OWN;
      end
      ST_OWN: begin
        if (!bus.grant) state_nxt = ST_ARB;
        else if (!busy) state_nxt = ST_START;
      end
      ST_START: state_nxt = ST_DATA;
      ST_DATA: begin
        if (done_evt) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Settle counter restarts on every entry to ARB, then holds so grant is re-sampled each clock.
  always_ff @(posedge nubus_clk) begin
    if (nubus_rst || state_q != ST_ARB) begin
      arb_cnt <= '0;
    end else if (!arb_done) begin
      arb_cnt <= arb_cnt + 1'b1;
    end
  end

  // Outputs are decoded from the next state so they line up with the registered state.
  assign hold_rqst = (state_nxt == ST_ARB) || (state_nxt == ST_OWN);
  assign drive_ad  = (state_nxt == ST_START) || (state_nxt == ST_DATA);

  always_ff @(posedge nubus_clk) begin
    if (nubus_rst) begin
      state_q              <= ST_IDLE;
      tm_q                 <= '0;
      bus.req_ready        <= 1'b0;
      bus.done_valid       <= 1'b0;
      bus.done_tm          <= '0;
      bus.done_timeout     <= 1'b0;
      bus.rqst_n           <= 1'b1;
      bus.rqst_oe_n        <= 1'b1;
      bus.arbcy_n          <= 1'b1;
      bus.nubus_master_dir <= 1'b0;
      bus.start_n          <= 1'b1;
      bus.tm_n             <= 2'b11;
      bus.ad_oe_n          <= 1'b1;
    end else begin
      state_q <= state_nxt;
      if (accept) tm_q <= bus.req_tm;
      bus.req_ready        <= accept;
      bus.done_valid       <= done_evt;
      bus.done_tm          <= ack_seen ? ~bus.tm_bus_n : TM_OK;
      bus.done_timeout     <= tmo_hit;
      bus.rqst_n           <= !hold_rqst;
      bus.rqst_oe_n        <= !hold_rqst;
      bus.arbcy_n          <= !hold_rqst;
      bus.nubus_master_dir <= drive_ad;
      bus.start_n          <= (state_nxt != ST_START);
      bus.tm_n             <= (state_nxt == ST_START) ? ~tm_q : 2'b11;
      bus.ad_oe_n          <= !drive_ad;
    end
  end

endmodule

// File: tb/tb_nubus_master_seq.sv
// tb_nubus_master_seq: directed vectors for the NuBus master sequencer (ARB_SETTLE=2, TIMEOUT=8).
// RQST and START are modelled as wired-OR lines combining this card with a foreign master.
module tb_nubus_master_seq;
  import nubus_pkg::*;

  logic nubus_clk;
  logic nubus_rst;
  logic other_rqst_n;
  logic other_start_n;
  int   n_chk;
  int   n_err;
  int   lat;

  nubus_master_seq_if bus_if ();

  assign bus_if.rqst_bus_n  = bus_if.rqst_n & other_rqst_n;
  assign bus_if.start_bus_n = bus_if.start_n & other_start_n;

  nubus_master_seq #(.ARB_SETTLE(2), .TIMEOUT(8)) dut (
    .nubus_clk (nubus_clk),
    .nubus_rst (nubus_rst),
    .bus       (bus_if)
  );

  initial nubus_clk = 1'b0;
  always #5 nubus_clk = ~nubus_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge nubus_clk);
    #1;
  endtask

  // Counts clocks from the request cycle to the first START cycle, dropping req_valid once accepted.
  task automatic wait_start(output int cyc);
    cyc = 0;
    while (bus_if.start_n !== 1'b0 && cyc < 64) begin
      step(1);
      cyc++;
      if (bus_if.req_ready === 1'b1) bus_if.req_valid = 1'b0;
    end
  endtask

  // Called in the START cycle: ACK arrives gap clocks later, completion is checked the clock after.
  task automatic do_ack(input string tag, input int gap, input logic [1:0] tmb, input logic [1:0] exp_tm);
    step(gap);
    bus_if.ack_bus_n = 1'b0;
    bus_if.tm_bus_n  = tmb;
    step(1);
    bus_if.ack_bus_n = 1'b1;
    bus_if.tm_bus_n  = 2'b11;
    chk({tag, "_done_valid"}, bus_if.done_valid, 1'b1);
    chk({tag, "_done_tm"}, bus_if.done_tm, exp_tm);
    chk({tag, "_done_timeout"}, bus_if.done_timeout, 1'b0);
    step(1);
    chk({tag, "_done_pulse"}, bus_if.done_valid, 1'b0);
  endtask

  task automatic check_released(input string tag);
    chk({tag, "_rqst_n"}, bus_if.rqst_n, 1'b1);
    chk({tag, "_rqst_oe_n"}, bus_if.rqst_oe_n, 1'b1);
    chk({tag, "_arbcy_n"}, bus_if.arbcy_n, 1'b1);
    chk({tag, "_dir"}, bus_if.nubus_master_dir, 1'b0);
    chk({tag, "_start_n"}, bus_if.start_n, 1'b1);
    chk({tag, "_tm_n"}, bus_if.tm_n, 2'b11);
    chk({tag, "_ad_oe_n"}, bus_if.ad_oe_n, 1'b1);
    chk({tag, "_req_ready"}, bus_if.req_ready, 1'b0);
    chk({tag, "_done_valid"}, bus_if.done_valid, 1'b0);
    chk({tag, "_done_tm"}, bus_if.done_tm, 2'b00);
    chk({tag, "_done_timeout"}, bus_if.done_timeout, 1'b0);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    nubus_rst        = 1'b1;
    other_rqst_n     = 1'b1;
    other_start_n    = 1'b1;
    bus_if.req_valid = 1'b0;
    bus_if.req_tm    = 2'b00;
    bus_if.grant     = 1'b0;
    bus_if.ack_bus_n = 1'b1;
    bus_if.tm_bus_n  = 2'b11;
    step(2);
    check_released("rst");
    nubus_rst = 1'b0;
    step(1);

    // Idle bus, immediate grant: START in the 4th clock after the request cycle.
    bus_if.req_valid = 1'b1;
    bus_if.req_tm    = TM_READ_WORD;
    bus_if.grant     = 1'b1;
    step(1);
    bus_if.req_valid = 1'b0;
    chk("t1_req_ready", bus_if.req_ready, 1'b1);
    chk("t1_arb_rqst_oe_n", bus_if.rqst_oe_n, 1'b0);
    chk("t1_arb_arbcy_n", bus_if.arbcy_n, 1'b0);
    step(1);
    chk("t1_req_ready_drop", bus_if.req_ready, 1'b0);
    step(1);
    chk("t1_no_early_start", bus_if.start_n, 1'b1);
    step(1);
    chk("t1_start_n", bus_if.start_n, 1'b0);
    chk("t1_tm_n", bus_if.tm_n, 2'b10);
    chk("t1_dir", bus_if.nubus_master_dir, 1'b1);
    chk("t1_ad_oe_n", bus_if.ad_oe_n, 1'b0);
    chk("t1_rqst_oe_rel", bus_if.rqst_oe_n, 1'b1);
    chk("t1_arbcy_rel", bus_if.arbcy_n, 1'b1);
    do_ack("t1", 3, 2'b11, TM_OK);

    // Fairness: foreign RQST held for 10 clocks from the request cycle.
    bus_if.req_valid = 1'b1;
    bus_if.req_tm    = TM_WRITE_WORD;
    other_rqst_n     = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step(1);
      if (k == 1) bus_if.req_valid = 1'b0;
      if (k == 10) other_rqst_n = 1'b1;
      chk("fair_rqst_hold", bus_if.rqst_n, 1'b1);
    end
    step(1);
    chk("fair_rqst_go", bus_if.rqst_n, 1'b0);
    wait_start(lat);
    chk("fair_start_lat", lat, 3);
    do_ack("fair", 1, 2'b10, TM_ERR);

    // Foreign cycle: START in the request cycle, its ACK 6 clocks later.
    bus_if.req_valid = 1'b1;
    bus_if.req_tm    = TM_WRITE_BYTE;
    other_start_n    = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step(1);
      if (k == 1) begin
        bus_if.req_valid = 1'b0;
        other_start_n    = 1'b1;
      end
      if (k == 6) bus_if.ack_bus_n = 1'b0;
      if (k == 7) bus_if.ack_bus_n = 1'b1;
      chk("busy_hold_start", bus_if.start_n, 1'b1);
    end
    step(1);
    chk("busy_start", bus_if.start_n, 1'b0);
    chk("busy_tm_n", bus_if.tm_n, 2'b01);
    do_ack("busy", 2, 2'b00, TM_RETRY);

    // Late grant: 5 ARB clocks without grant, then START 2 clocks after grant rises.
    bus_if.grant     = 1'b0;
    bus_if.req_valid = 1'b1;
    bus_if.req_tm    = TM_READ_BYTE;
    for (int k = 1; k <= 5; k++) begin
      step(1);
      if (k == 1) bus_if.req_valid = 1'b0;
      chk("gnt_arbcy", bus_if.arbcy_n, 1'b0);
    end
    step(1);
    bus_if.grant = 1'b1;
    chk("gnt_rqst_oe", bus_if.rqst_oe_n, 1'b0);
    step(1);
    chk("gnt_own_start_n", bus_if.start_n, 1'b1);
    chk("gnt_own_rqst_oe", bus_if.rqst_oe_n, 1'b0);
    step(1);
    chk("gnt_start_n", bus_if.start_n, 1'b0);
    chk("gnt_rqst_oe_rel", bus_if.rqst_oe_n, 1'b1);
    chk("gnt_rqst_rel", bus_if.rqst_n, 1'b1);
    chk("gnt_arbcy_rel", bus_if.arbcy_n, 1'b1);
    do_ack("gnt", 1, 2'b01, TM_TMO);

    // No ACK at all.
    bus_if.req_valid = 1'b1;
    bus_if.req_tm    = TM_READ_WORD;
    wait_start(lat);
    chk("tmo_start_lat", lat, 4);
`ifdef NUBUS_MASTER_TIMEOUT_EN
    for (int k = 1; k <= 8; k++) begin
      step(1);
      chk("tmo_wait_done", bus_if.done_valid, 1'b0);
      chk("tmo_wait_dir", bus_if.nubus_master_dir, 1'b1);
    end
    step(1);
    chk("tmo_done_valid", bus_if.done_valid, 1'b1);
    chk("tmo_done_timeout", bus_if.done_timeout, 1'b1);
    chk("tmo_done_tm", bus_if.done_tm, 2'b00);
    chk("tmo_dir_rel", bus_if.nubus_master_dir, 1'b0);
    // Our own unanswered START leaves the bus marked busy; reset clears it before the next cycle.
    nubus_rst = 1'b1;
    step(1);
    nubus_rst = 1'b0;
    step(1);
    bus_if.req_valid = 1'b1;
    wait_start(lat);
    chk("rst_start_lat", lat, 4);
    step(2);
`else
    for (int k = 1; k <= 20; k++) begin
      step(1);
      chk("noto_wait_done", bus_if.done_valid, 1'b0);
      chk("noto_wait_dir", bus_if.nubus_master_dir, 1'b1);
    end
`endif

    // Reset while in DATA, with ACK arriving in the same clock.
    chk("rst_in_data_dir", bus_if.nubus_master_dir, 1'b1);
    nubus_rst        = 1'b1;
    bus_if.ack_bus_n = 1'b0;
    step(1);
    nubus_rst        = 1'b0;
    bus_if.ack_bus_n = 1'b1;
    check_released("rst_data");
    step(1);
    chk("rst_data_no_done", bus_if.done_valid, 1'b0);
    chk("rst_data_idle_rqst", bus_if.rqst_oe_n, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
